// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and Johnson code helpers for the decoder slice
package johnson_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } jstate_e;

    localparam int JMAX_W = 32;
    localparam int JIDX_W = 6;

    typedef struct packed {
        logic              legal;
        logic [JIDX_W-1:0] index;
    } jdec_t;

    // Phase k <= width fills k ones from the bottom; past width the ones drain from the bottom.
    function automatic logic [JMAX_W-1:0] johnson_code(input int unsigned index,
                                                       input int unsigned width);
        logic [JMAX_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < JMAX_W; i++) begin
            if (i < width) begin
                c[i] = (index <= width) ? (i < index) : (i >= index - width);
            end
        end
        return c;
    endfunction

    function automatic jdec_t johnson_phase(input logic [JMAX_W-1:0] code,
                                            input int unsigned width);
        jdec_t d;
        d = '0;
        for (int unsigned k = 0; k < 2 * JMAX_W; k++) begin
            if ((k < 2 * width) && !d.legal && (code == johnson_code(k, width))) begin
                d.legal = 1'b1;
                d.index = k[JIDX_W-1:0];
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/johnson_code_lut.sv
// rtl/johnson_code_lut.sv - combinational Johnson code validator and phase decoder
module johnson_code_lut
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PH_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] code_i,
    output logic             legal_o,
    output logic [PH_W-1:0]  index_o
);

    logic [JMAX_W-1:0] code_ext;
    jdec_t             dec;

    always_comb begin
        code_ext              = '0;
        code_ext[WIDTH-1:0]   = code_i;
        dec                   = johnson_phase(code_ext, WIDTH);
    end

    assign legal_o = dec.legal;
    assign index_o = dec.index[PH_W-1:0];

endmodule

// File: rtl/johnson_code_decoder.sv
// rtl/johnson_code_decoder.sv - Johnson code decoder with lock tracking and error counting
module johnson_code_decoder
    import johnson_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8,
    localparam int PH_W    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  logic [WIDTH-1:0] code_in,
    input  logic             err_clr,
    output logic [PH_W-1:0]  phase,
    output logic             phase_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [PH_W-1:0]  LAST_PH = PH_W'(2 * WIDTH - 1);
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic            lut_legal;
    logic [PH_W-1:0] lut_index;

    johnson_code_lut #(.WIDTH(WIDTH)) u_lut (
        .code_i  (code_in),
        .legal_o (lut_legal),
        .index_o (lut_index)
    );

    jstate_e          state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             pv_q, pv_d;
    logic             ill_q, ill_d;
    logic             serr_q, serr_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [PH_W-1:0]  phase_exp;
    logic             in_order;
    logic             err_inc;

    assign phase_exp = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
    assign in_order  = lut_legal && (lut_index == phase_exp);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        phase_d = phase_q;
        pv_d    = 1'b0;
        ill_d   = 1'b0;
        serr_d  = 1'b0;
        err_inc = 1'b0;

        if (code_valid) begin
            if (lut_legal) begin
                phase_d = lut_index;
                pv_d    = 1'b1;
            end else begin
                ill_d   = 1'b1;
            end

            unique case (state_q)
                HUNT: begin
                    if (lut_legal) begin
                        run_d   = 4'd1;
                        state_d = (LOCK_C == 4'd1) ? LOCKED : CHECK;
                    end
                end
                CHECK: begin
                    if (!lut_legal) begin
                        run_d   = 4'd0;
                        state_d = HUNT;
                    end else if (in_order) begin
                        run_d = run_q + 4'd1;
                        if (run_q + 4'd1 == LOCK_C) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        // An out-of-order legal code becomes the new seed of the run.
                        run_d = 4'd1;
                    end
                end
                LOCKED: begin
                    if (!in_order) begin
                        serr_d  = 1'b1;
                        err_inc = 1'b1;
                        run_d   = 4'd0;
                        state_d = HUNT;
                    end
                end
                default: begin
                    run_d   = 4'd0;
                    state_d = HUNT;
                end
            endcase
        end

        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end else if (err_inc && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HUNT;
            run_q   <= 4'd0;
            phase_q <= '0;
            pv_q    <= 1'b0;
            ill_q   <= 1'b0;
            serr_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            phase_q <= phase_d;
            pv_q    <= pv_d;
            ill_q   <= ill_d;
            serr_q  <= serr_d;
            err_q   <= err_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = pv_q;
    assign illegal     = ill_q;
    assign seq_err     = serr_q;
    assign locked      = (state_q == LOCKED);
    assign err_count   = err_q;

endmodule

// File: tb/tb_johnson_code_decoder.sv
// tb/tb_johnson_code_decoder.sv - directed self-checking bench for johnson_code_decoder
module tb_johnson_code_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       code_valid = 1'b0;
    logic [3:0] code_in = 4'b0000;
    logic       err_clr = 1'b0;
    logic [2:0] phase;
    logic       phase_valid;
    logic       illegal;
    logic       seq_err;
    logic       locked;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    johnson_code_decoder #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .code_valid  (code_valid),
        .code_in     (code_in),
        .err_clr     (err_clr),
        .phase       (phase),
        .phase_valid (phase_valid),
        .illegal     (illegal),
        .seq_err     (seq_err),
        .locked      (locked),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] c, input logic clr);
        @(negedge clk);
        code_valid = v;
        code_in    = c;
        err_clr    = clr;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        err_clr    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({phase, phase_valid, illegal, seq_err, locked} !== 7'b0 || err_count !== 8'd0) begin $display("FAIL reset_init: phase=%0d pv=%0b ill=%0b serr=%0b lk=%0b err=%0d, want all 0", phase, phase_valid, illegal, seq_err, locked, err_count); n_fail++; end
        @(negedge clk); reset = 1'b1;
        drive(1, 4'b0000, 0); drive(1, 4'b0001, 0); drive(1, 4'b0011, 0);
        n_checks++; if (locked !== 1'b1 || phase !== 3'd2) begin $display("FAIL reset_prelock: lk=%0b phase=%0d, want 1 2", locked, phase); n_fail++; end
        #3 reset = 1'b0;
        #1;
        n_checks++; if (locked !== 1'b0 || phase !== 3'd0 || phase_valid !== 1'b0) begin $display("FAIL reset_async: lk=%0b phase=%0d pv=%0b, want 0 0 0", locked, phase, phase_valid); n_fail++; end
        @(negedge clk); reset = 1'b1;
        drive(1, 4'b0111, 0);
        drive(1, 4'b1111, 0);
        n_checks++; if (locked !== 1'b0 || phase !== 3'd4) begin $display("FAIL reset_history: lk=%0b phase=%0d, want 0 4", locked, phase); n_fail++; end
        drive(1, 4'b1110, 0);
        n_checks++; if (locked !== 1'b1 || phase !== 3'd5) begin $display("FAIL reset_relock: lk=%0b phase=%0d, want 1 5", locked, phase); n_fail++; end
    endtask

    task automatic test_lock();
        logic [3:0] codes [3];
        codes = '{4'b0000, 4'b0001, 4'b0011};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, codes[i], 0);
            n_checks++; if (phase !== 3'(i) || phase_valid !== 1'b1 || locked !== (i == 2)) begin $display("FAIL lock_%0d: phase=%0d pv=%0b lk=%0b, want %0d 1 %0b", i, phase, phase_valid, locked, i, (i == 2)); n_fail++; end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] codes [4];
        logic [2:0] exp_ph [4];
        codes  = '{4'b1100, 4'b1000, 4'b0000, 4'b0001};
        exp_ph = '{3'd6, 3'd7, 3'd0, 3'd1};
        drive(1, 4'b0111, 0); drive(1, 4'b1111, 0); drive(1, 4'b1110, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, codes[i], 0);
            n_checks++; if (phase !== exp_ph[i] || seq_err !== 1'b0 || locked !== 1'b1) begin $display("FAIL wrap_%0d: phase=%0d serr=%0b lk=%0b, want %0d 0 1", i, phase, seq_err, locked, exp_ph[i]); n_fail++; end
        end
    endtask

    task automatic test_illegal();
        drive(1, 4'b0101, 0);
        n_checks++; if (illegal !== 1'b1 || seq_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || phase !== 3'd1 || phase_valid !== 1'b0) begin $display("FAIL illegal_locked: ill=%0b serr=%0b err=%0d lk=%0b phase=%0d pv=%0b, want 1 1 1 0 1 0", illegal, seq_err, err_count, locked, phase, phase_valid); n_fail++; end
        drive(1, 4'b0111, 0); drive(1, 4'b1111, 0);
        n_checks++; if (locked !== 1'b0 || illegal !== 1'b0) begin $display("FAIL illegal_relock_early: lk=%0b ill=%0b, want 0 0", locked, illegal); n_fail++; end
        drive(1, 4'b1110, 0);
        n_checks++; if (locked !== 1'b1 || phase !== 3'd5 || err_count !== 8'd1) begin $display("FAIL illegal_relock: lk=%0b phase=%0d err=%0d, want 1 5 1", locked, phase, err_count); n_fail++; end
    endtask

    task automatic test_skip_repeat();
        do_reset();
        drive(1, 4'b0000, 0); drive(1, 4'b0001, 0); drive(1, 4'b0011, 0);
        drive(1, 4'b1111, 0);
        n_checks++; if (seq_err !== 1'b1 || phase !== 3'd4 || err_count !== 8'd1 || locked !== 1'b0) begin $display("FAIL skip: serr=%0b phase=%0d err=%0d lk=%0b, want 1 4 1 0", seq_err, phase, err_count, locked); n_fail++; end
        drive(1, 4'b1110, 0); drive(1, 4'b1100, 0); drive(1, 4'b1000, 0);
        n_checks++; if (locked !== 1'b1 || phase !== 3'd7 || seq_err !== 1'b0) begin $display("FAIL skip_relock: lk=%0b phase=%0d serr=%0b, want 1 7 0", locked, phase, seq_err); n_fail++; end
        drive(1, 4'b1000, 0);
        n_checks++; if (seq_err !== 1'b1 || err_count !== 8'd2 || phase !== 3'd7 || phase_valid !== 1'b1 || locked !== 1'b0) begin $display("FAIL repeat: serr=%0b err=%0d phase=%0d pv=%0b lk=%0b, want 1 2 7 1 0", seq_err, err_count, phase, phase_valid, locked); n_fail++; end
    endtask

    task automatic test_counter();
        for (int i = 0; i < 253; i++) begin
            drive(1, 4'b0000, 0); drive(1, 4'b0001, 0); drive(1, 4'b0011, 0); drive(1, 4'b0101, 0);
        end
        n_checks++; if (err_count !== 8'd255) begin $display("FAIL cnt_255: err=%0d, want 255", err_count); n_fail++; end
        drive(1, 4'b0000, 0); drive(1, 4'b0001, 0); drive(1, 4'b0011, 0); drive(1, 4'b0101, 0);
        n_checks++; if (err_count !== 8'd255 || seq_err !== 1'b1) begin $display("FAIL cnt_sat: err=%0d serr=%0b, want 255 1", err_count, seq_err); n_fail++; end
        drive(1, 4'b0000, 0); drive(1, 4'b0001, 0); drive(1, 4'b0011, 0); drive(1, 4'b0101, 1);
        n_checks++; if (err_count !== 8'd0 || seq_err !== 1'b1 || illegal !== 1'b1) begin $display("FAIL cnt_clr: err=%0d serr=%0b ill=%0b, want 0 1 1", err_count, seq_err, illegal); n_fail++; end
        drive(1, 4'b0101, 0);
        n_checks++; if (illegal !== 1'b1 || seq_err !== 1'b0 || err_count !== 8'd0) begin $display("FAIL hunt_illegal: ill=%0b serr=%0b err=%0d, want 1 0 0", illegal, seq_err, err_count); n_fail++; end
    endtask

    task automatic test_gap();
        drive(1, 4'b0000, 0); drive(1, 4'b0001, 0); drive(1, 4'b0011, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'b1111, 0);
            n_checks++; if (phase !== 3'd2 || locked !== 1'b1 || phase_valid !== 1'b0 || illegal !== 1'b0 || seq_err !== 1'b0) begin $display("FAIL gap_%0d: phase=%0d lk=%0b pv=%0b ill=%0b serr=%0b, want 2 1 0 0 0", i, phase, locked, phase_valid, illegal, seq_err); n_fail++; end
        end
        drive(1, 4'b0111, 0);
        n_checks++; if (phase !== 3'd3 || locked !== 1'b1 || seq_err !== 1'b0 || phase_valid !== 1'b1) begin $display("FAIL gap_resume: phase=%0d lk=%0b serr=%0b pv=%0b, want 3 1 0 1", phase, locked, seq_err, phase_valid); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_illegal();
        test_skip_repeat();
        test_counter();
        test_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
